run_dump_monitor: RTL and testbench
===================================

Name: run_dump_monitor

Overview:
- Synthesizable run-control and result-dump block for the single-cycle MIPS core.
- Watches the core PC for a configurable end address and enforces a cycle-limit timeout.
- On end or timeout, freezes the core and streams a configurable window of data-memory words out over a valid/ready port.
- Replaces the simulation-only end-of-program check and memory print, so the same flow runs on silicon or FPGA.

Parameters:
- ADDR_W, 32, PC and data-memory address width.
- DATA_W, 32, data-memory word width.
- END_PC, 32'h78, PC value that marks program completion.
- DUMP_BASE, 32, first data-memory word index dumped.
- DUMP_WORDS, 96, number of words dumped (>=1).
- ROW_WORDS, 16, words per output row; drives dump_eol.
- MAX_CYCLES, 100000, RUN cycles allowed before timeout (>=2).
- CYC_W, 32, cycle counter width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  start/arm monitoring; level-sensitive.
- pc  in  ADDR_W  current core PC.
- hold_cpu  out  1  freezes core PC/register/memory writes while high.
- mem_addr  out  ADDR_W  data-memory word index for the read port.
- mem_rdata  in  DATA_W  combinational read data for mem_addr, valid in the same cycle.
- dump_data  out  DATA_W  streamed word.
- dump_valid  out  1  dump_data valid.
- dump_ready  in  1  sink accepts the word.
- dump_eol  out  1  current word ends a row.
- dump_last  out  1  current word is the final word.
- done  out  1  dump complete.
- timeout  out  1  dump was triggered by the cycle limit, not by END_PC.
- cycle_count  out  CYC_W  RUN cycles elapsed, saturating.

Behaviour:
- Reset (async, reset=0):
  - state=IDLE, idx=0, cycle_count=0.
  - All outputs 0; mem_addr=DUMP_BASE.
- States: IDLE, RUN, DUMP, DONE.
- IDLE: if enable=1, go to RUN next cycle with cycle_count=0.
- RUN:
  - cycle_count increments each cycle and saturates at all-ones.
  - If pc==END_PC: go to DUMP with timeout=0.
  - Else if cycle_count==MAX_CYCLES-1: go to DUMP with timeout=1.
  - pc match and limit in the same cycle: the match wins and timeout=0.
  - enable=0: go to IDLE and clear cycle_count.
- hold_cpu: 1 in DUMP and DONE; 0 otherwise.
- DUMP:
  - mem_addr = DUMP_BASE + idx, truncated to ADDR_W.
  - dump_data = mem_rdata, combinational pass-through.
  - dump_valid=1 throughout the state.
  - dump_eol=1 when (idx+1)%ROW_WORDS==0, or when idx==DUMP_WORDS-1.
  - dump_last=1 when idx==DUMP_WORDS-1.
  - On dump_valid&dump_ready: idx increments; on the last word, go to DONE.
  - With dump_ready=0, data and address hold stable, with no loss and no duplication.
  - enable is ignored in DUMP; the dump always completes.
- DONE:
  - done=1; timeout and cycle_count hold; dump_valid=0.
  - enable=0: go to IDLE, clearing done, timeout, idx and cycle_count.
- Latency:
  - First dump word is valid the cycle after the END_PC match is sampled.
  - With ready held high, one word is transferred per cycle: DUMP_WORDS cycles, then done the following cycle.
- timeout is registered on entry to DUMP and is stable through DUMP and DONE.
- Reset mid-operation (any state) returns to IDLE immediately; no partial state survives.

Test Plan:
- Normal end: enable=1, pc steps 0,4,...,0x78, dump_ready=1 → hold_cpu rises the cycle after pc=0x78; 96 words with mem_addr 32..127 in order; dump_eol at idx 15,31,...,95; dump_last only at idx 95; done=1 next cycle; timeout=0; cycle_count=31.
- Backpressure: dump_ready toggles 1,0,0,1 pattern → each word is transferred exactly once; dump_data and mem_addr are stable while ready=0; total of 96 handshakes.
- Timeout: MAX_CYCLES=20, pc never equals END_PC → DUMP entered after cycle_count=19; timeout=1; full dump; done=1 with timeout still 1.
- Simultaneous: MAX_CYCLES=8, pc=END_PC on the cycle cycle_count=7 → timeout=0, dump proceeds normally.
- Abort/restart: enable dropped in RUN at cycle 5 → IDLE with cycle_count=0. enable dropped mid-DUMP → dump continues to done. Deassert in DONE, then reassert → a fresh run with cleared flags.
- Async reset mid-DUMP at idx=40 → all outputs 0 immediately without a clock edge; after release with enable=1, RUN restarts and the dump restarts at idx=0.

Source files
------------

// File: rtl/run_dump_monitor_if.sv
// run_dump_monitor_if: data-memory read port plus the streamed dump port.
//   mem_addr   : word index driven by the monitor
//   mem_rdata  : combinational read data for mem_addr
//   dump_data  : streamed word
//   dump_valid : dump_data is valid
//   dump_ready : sink accepts the word
//   dump_eol   : current word ends a row
//   dump_last  : current word is the final word
// master = monitor side, slave = memory/sink side.
interface run_dump_monitor_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] dump_data;
  logic              dump_valid;
  logic              dump_ready;
  logic              dump_eol;
  logic              dump_last;

  modport master (
    output mem_addr, dump_data, dump_valid, dump_eol, dump_last,
    input  mem_rdata, dump_ready
  );
  modport slave (
    input  mem_addr, dump_data, dump_valid, dump_eol, dump_last,
    output mem_rdata, dump_ready
  );
endinterface

// File: rtl/run_dump_monitor.sv
// run_dump_monitor: run control and result dump for the single-cycle MIPS core.
// Watches pc for END_PC, enforces a RUN cycle limit, then freezes the core and
// streams DUMP_WORDS data-memory words starting at DUMP_BASE over a valid/ready
// port.
//   clk, reset (async, active low), enable (level arm)
//   pc          : current core PC
//   hold_cpu    : freeze core state updates while high
//   bus         : memory read port + dump stream (master modport)
//   done        : dump complete
//   timeout     : dump was triggered by the cycle limit
//   cycle_count : RUN cycles elapsed, saturating
module run_dump_monitor #(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter logic [ADDR_W-1:0] END_PC     = ADDR_W'(32'h78),
  parameter int                DUMP_BASE  = 32,
  parameter int                DUMP_WORDS = 96,
  parameter int                ROW_WORDS  = 16,
  parameter int                MAX_CYCLES = 100000,
  parameter int                CYC_W      = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [ADDR_W-1:0]    pc,
  output logic                 hold_cpu,
  run_dump_monitor_if.master   bus,
  output logic                 done,
  output logic                 timeout,
  output logic [CYC_W-1:0]     cycle_count
);
  localparam int IDX_W = (DUMP_WORDS > 1) ? $clog2(DUMP_WORDS) : 1;
  localparam int COL_W = (ROW_WORDS > 1) ? $clog2(ROW_WORDS) : 1;
  localparam logic [CYC_W-1:0] LIMIT    = CYC_W'(MAX_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DUMP_WORDS - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(ROW_WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DUMP, DONE} state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  // Column within the current row; avoids a modulo on idx for dump_eol.
  logic [COL_W-1:0] col;
  logic             dump_vld;
  logic             last_w;
  logic             pc_hit;

  assign last_w = (idx == LAST_IDX);
  assign pc_hit = (pc == END_PC);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      idx         <= '0;
      col         <= '0;
      cycle_count <= '0;
      hold_cpu    <= 1'b0;
      dump_vld    <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            state       <= RUN;
            cycle_count <= '0;
          end
        end
        RUN: begin
          if (!enable) begin
            state       <= IDLE;
            cycle_count <= '0;
          end else begin
            // The triggering cycle is itself a RUN cycle and is counted.
            if (cycle_count != '1) cycle_count <= cycle_count + 1'b1;
            if (pc_hit || cycle_count == LIMIT) begin
              state    <= DUMP;
              timeout  <= !pc_hit;  // a pc match beats a coincident limit
              hold_cpu <= 1'b1;
              dump_vld <= 1'b1;
              idx      <= '0;
              col      <= '0;
            end
          end
        end
        DUMP: begin
          // enable is deliberately ignored: the dump always completes.
          if (bus.dump_ready) begin
            if (last_w) begin
              state    <= DONE;
              dump_vld <= 1'b0;
              done     <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
              col <= (col == LAST_COL) ? '0 : col + 1'b1;
            end
          end
        end
        DONE: begin
          if (!enable) begin
            state       <= IDLE;
            done        <= 1'b0;
            timeout     <= 1'b0;
            hold_cpu    <= 1'b0;
            idx         <= '0;
            col         <= '0;
            cycle_count <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_addr   = ADDR_W'(DUMP_BASE) + ADDR_W'(idx);
  assign bus.dump_valid = dump_vld;
  assign bus.dump_data  = dump_vld ? bus.mem_rdata : '0;
  assign bus.dump_last  = dump_vld & last_w;
  assign bus.dump_eol   = dump_vld & ((col == LAST_COL) | last_w);
endmodule

// File: tb/tb_run_dump_monitor.sv
// Bench for run_dump_monitor. Three instances share the stimulus and differ only
// in MAX_CYCLES (100000, 20, 8); each test checks the instance it targets.
module tb_run_dump_monitor;
  localparam int AW = 32, DW = 32, NI = 3;
  localparam logic [31:0] END_PC = 32'h78;
  localparam int BASE = 32, NW = 96, ROW = 16;

  typedef struct packed {
    logic          hold;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          valid, eol, last, done, tmo;
    logic [31:0]   cyc;
  } obs_t;

  typedef struct {
    int         k;       // instance under test
    int         match;   // RUN cycle with pc==END_PC, -1 = never
    logic [3:0] pat;     // dump_ready pattern, bit (cycle%4)
    logic       exp_tmo;
    int         exp_cyc;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [31:0] pc = '0;
  logic        dump_ready = 1'b0;
  obs_t        obs [NI];
  int          n_run = 0, n_fail = 0, hs = 0;

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {16'hBEEF, a[15:0] ^ 16'h0F0F};
  endfunction

  function automatic int maxc(input int k);
    return (k == 0) ? 100000 : ((k == 1) ? 20 : 8);
  endfunction

  function automatic logic [31:0] pcv(input int match, input int n);
    if (match < 0) return 32'h1000 + 32'(4 * n);
    return (n == match) ? END_PC : 32'(4 * n);
  endfunction

  for (genvar g = 0; g < NI; g++) begin : gd
    logic        hold, done, tmo;
    logic [31:0] cyc;
    run_dump_monitor_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    assign bus.mem_rdata  = mem_word(bus.mem_addr);
    assign bus.dump_ready = dump_ready;
    run_dump_monitor #(.MAX_CYCLES((g == 0) ? 100000 : ((g == 1) ? 20 : 8))) dut (
      .clk(clk), .reset(reset), .enable(enable), .pc(pc), .hold_cpu(hold),
      .bus(bus), .done(done), .timeout(tmo), .cycle_count(cyc)
    );
    assign obs[g] = '{hold, bus.mem_addr, bus.dump_data, bus.dump_valid,
                      bus.dump_eol, bus.dump_last, done, tmo, cyc};
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0; enable = 1'b0; dump_ready = 1'b0; pc = '0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  // Arms the monitor and steps pc until the trigger; ends in the first DUMP cycle.
  task automatic do_run(input int k, input int match);
    int trig;
    trig = (match >= 0) ? match : maxc(k) - 1;
    enable = 1'b1; pc = pcv(match, 0);
    @(posedge clk); #1;
    for (int n = 0; n <= trig; n++) begin
      pc = pcv(match, n);
      chk("run_cycle_count", obs[k].cyc, 64'(n));
      chk("run_hold_low", obs[k].hold, 0);
      @(posedge clk); #1;
    end
    chk("entry_hold", obs[k].hold, 1);
    chk("entry_valid", obs[k].valid, 1);
    hs = 0;
  endtask

  // Streams words until hs reaches stop_at; drops enable when hs == drop_at.
  task automatic do_dump(input int k, input logic [3:0] pat, input int stop_at,
                         input int drop_at, input logic exp_tmo);
    int c;
    c = 0;
    while (hs < stop_at && c < 1000) begin
      chk("dump_valid", obs[k].valid, 1);
      chk("dump_addr", obs[k].addr, 64'(BASE + hs));
      chk("dump_data", obs[k].data, mem_word(32'(BASE + hs)));
      chk("dump_eol", obs[k].eol, (((hs + 1) % ROW) == 0 || hs == NW - 1) ? 1 : 0);
      chk("dump_last", obs[k].last, (hs == NW - 1) ? 1 : 0);
      chk("dump_done_low", obs[k].done, 0);
      chk("dump_hold", obs[k].hold, 1);
      chk("dump_timeout", obs[k].tmo, exp_tmo);
      dump_ready = pat[c % 4];
      if (hs == drop_at) enable = 1'b0;
      @(posedge clk); #1;
      if (dump_ready) hs++;
      c++;
    end
    chk("dump_handshakes", 64'(hs), 64'(stop_at));
  endtask

  task automatic chk_done(input int k, input logic exp_tmo, input int exp_cyc);
    chk("done_flag", obs[k].done, 1);
    chk("done_valid_low", obs[k].valid, 0);
    chk("done_last_low", obs[k].last, 0);
    chk("done_hold", obs[k].hold, 1);
    chk("done_timeout", obs[k].tmo, exp_tmo);
    chk("done_cycle_count", obs[k].cyc, 64'(exp_cyc));
  endtask

  vec_t vt [5];

  initial begin
    vt[0] = '{0, 30, 4'b1111, 1'b0, 31};  // normal end
    vt[1] = '{0, 30, 4'b1001, 1'b0, 31};  // ready 1,0,0,1
    vt[2] = '{1, -1, 4'b1111, 1'b1, 20};  // timeout, limit 20
    vt[3] = '{2,  7, 4'b1111, 1'b0,  8};  // match and limit together
    vt[4] = '{1, -1, 4'b0110, 1'b1, 20};  // timeout with backpressure

    // Async reset, checked before the first clock edge.
    #2 reset = 1'b0;
    #2;
    chk("rst_hold", obs[0].hold, 0);
    chk("rst_addr", obs[0].addr, BASE);
    chk("rst_data", obs[0].data, 0);
    chk("rst_valid", obs[0].valid, 0);
    chk("rst_eol_last", {obs[0].eol, obs[0].last}, 0);
    chk("rst_done_tmo", {obs[0].done, obs[0].tmo}, 0);
    chk("rst_cycles", obs[0].cyc, 0);

    for (int i = 0; i < 5; i++) begin
      do_reset();
      do_run(vt[i].k, vt[i].match);
      do_dump(vt[i].k, vt[i].pat, NW, -1, vt[i].exp_tmo);
      chk_done(vt[i].k, vt[i].exp_tmo, vt[i].exp_cyc);
      @(posedge clk); #1;  // DONE holds while enable stays high
      chk_done(vt[i].k, vt[i].exp_tmo, vt[i].exp_cyc);
    end

    // Abort in RUN after 5 cycles.
    do_reset();
    enable = 1'b1; pc = 32'h200;
    @(posedge clk); #1;
    repeat (5) begin @(posedge clk); #1; end
    chk("abort_count_5", obs[0].cyc, 5);
    enable = 1'b0;
    @(posedge clk); #1;
    chk("abort_count_clr", obs[0].cyc, 0);
    chk("abort_hold", obs[0].hold, 0);

    // enable dropped mid-DUMP: dump still completes, then back to IDLE.
    do_reset();
    do_run(0, 30);
    do_dump(0, 4'b1111, NW, 10, 1'b0);
    chk_done(0, 1'b0, 31);
    @(posedge clk); #1;
    chk("drop_idle_done", obs[0].done, 0);
    chk("drop_idle_hold", obs[0].hold, 0);
    chk("drop_idle_cycles", obs[0].cyc, 0);

    // Deassert in DONE after a timeout, then re-arm.
    do_reset();
    do_run(1, -1);
    do_dump(1, 4'b1111, NW, -1, 1'b1);
    chk_done(1, 1'b1, 20);
    enable = 1'b0;
    @(posedge clk); #1;
    chk("rearm_idle_tmo", obs[1].tmo, 0);
    chk("rearm_idle_done", obs[1].done, 0);
    chk("rearm_idle_cycles", obs[1].cyc, 0);
    enable = 1'b1;
    @(posedge clk); #1;
    chk("rearm_run_cycles", obs[1].cyc, 0);
    chk("rearm_run_flags", {obs[1].hold, obs[1].tmo, obs[1].done}, 0);
    @(posedge clk); #1;
    chk("rearm_run_count1", obs[1].cyc, 1);

    // Async reset at idx 40, then a fresh run from idx 0.
    do_reset();
    do_run(0, 30);
    do_dump(0, 4'b1111, 40, -1, 1'b0);
    chk("mid_addr_40", obs[0].addr, BASE + 40);
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_hold", obs[0].hold, 0);
    chk("mid_rst_addr", obs[0].addr, BASE);
    chk("mid_rst_valid", {obs[0].valid, obs[0].eol, obs[0].last}, 0);
    chk("mid_rst_data", obs[0].data, 0);
    chk("mid_rst_flags", {obs[0].done, obs[0].tmo}, 0);
    chk("mid_rst_cycles", obs[0].cyc, 0);
    #1 reset = 1'b1;
    do_run(0, 30);
    do_dump(0, 4'b1111, NW, -1, 1'b0);
    chk_done(0, 1'b0, 31);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
